// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin 3-port front end for one memory master; requester buses in (req/rw/addr/len/fifo_*/release_req), grant/done back, one muxed m_* transaction out, m_ready/m_done in, sticky timeout_err/timeout_port watchdog
module mem_arbiter #(
  parameter int NREQ = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rw,
  input  logic [64*NREQ-1:0]   addr,
  input  logic [8*NREQ-1:0]    len,
  input  logic [9*NREQ-1:0]    fifo_idx,
  input  logic [64*NREQ-1:0]   fifo_wdata,
  input  logic [NREQ-1:0]      fifo_wen,
  input  logic [NREQ-1:0]      release_req,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 m_req,
  output logic                 m_rw,
  output logic [63:0]          m_addr,
  output logic [7:0]           m_len,
  output logic [8:0]           m_fifo_idx,
  output logic [63:0]          m_fifo_wdata,
  output logic                 m_fifo_wen,
  output logic                 m_release,
  input  logic                 m_ready,
  input  logic                 m_done,
  output logic                 timeout_err,
  output logic [1:0]           timeout_port
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [1:0] sel, last_gnt, p1, p2, pick;
  logic lat_rw, busy;
  logic [63:0] lat_addr;
  logic [7:0] lat_len;
  logic [12:0] wd;
  always_comb begin
    p1 = last_gnt == 2'd2 ? 2'd0 : last_gnt + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    pick = req[p1] ? p1 : req[p2] ? p2 : last_gnt;
    busy = state != IDLE;
    m_release = state == WAIT_DONE && m_done && release_req[sel];
    state_nx = state == IDLE ? ((m_ready && |req) ? ISSUE : IDLE) :
               state == ISSUE ? WAIT_DONE : (m_release ? IDLE : WAIT_DONE);
    gnt = busy ? NREQ'(1) << sel : '0;
    done = (state == WAIT_DONE && m_done) ? NREQ'(1) << sel : '0;
    m_req = state == ISSUE;
    m_rw = busy && lat_rw;
    m_addr = busy ? lat_addr : '0;
    m_len = busy ? lat_len : '0;
    m_fifo_idx = busy ? fifo_idx[9*sel +: 9] : '0;
    m_fifo_wdata = busy ? fifo_wdata[64*sel +: 64] : '0;
    m_fifo_wen = busy && fifo_wen[sel];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_gnt <= 2'd2;
      sel <= '0;
      lat_rw <= 1'b0;
      lat_addr <= '0;
      lat_len <= '0;
      wd <= '0;
      timeout_err <= 1'b0;
      timeout_port <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == ISSUE) begin
        sel <= pick;
        lat_rw <= rw[pick];
        lat_addr <= addr[64*pick +: 64];
        lat_len <= len[8*pick +: 8];
      end
      if (m_release) last_gnt <= sel;
      if (state == ISSUE) wd <= '0;
      else if (state == WAIT_DONE && !m_done && wd != 13'(TIMEOUT)) begin
        wd <= wd + 13'd1;
        if (wd + 13'd1 == 13'(TIMEOUT)) begin
          timeout_err <= 1'b1;
          timeout_port <= sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized round-robin transactions checked against a behavioural arbiter model
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic [2:0] req = 0, rw = 0, fifo_wen = 0, release_req = 0, gnt, done;
  logic [191:0] addr = 0, fifo_wdata = 0;
  logic [23:0] len = 0;
  logic [26:0] fifo_idx = 0;
  logic m_req, m_rw, m_fifo_wen, m_release, m_ready = 0, m_done = 0, timeout_err;
  logic [63:0] m_addr, m_fifo_wdata;
  logic [7:0] m_len;
  logic [8:0] m_fifo_idx;
  logic [1:0] timeout_port;
  int n_tests = 0, n_fail = 0, model_last = 2;
  mem_arbiter #(.NREQ(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .len(len),
    .fifo_idx(fifo_idx), .fifo_wdata(fifo_wdata), .fifo_wen(fifo_wen),
    .release_req(release_req), .gnt(gnt), .done(done), .m_req(m_req), .m_rw(m_rw),
    .m_addr(m_addr), .m_len(m_len), .m_fifo_idx(m_fifo_idx), .m_fifo_wdata(m_fifo_wdata),
    .m_fifo_wen(m_fifo_wen), .m_release(m_release), .m_ready(m_ready), .m_done(m_done),
    .timeout_err(timeout_err), .timeout_port(timeout_port)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++)
      if (r[(model_last + k) % 3]) return (model_last + k) % 3;
    return 0;
  endfunction
  task automatic rand_fields;
    for (int i = 0; i < 3; i++) begin
      addr[64*i +: 64] = {$urandom, $urandom};
      fifo_wdata[64*i +: 64] = {$urandom, $urandom};
      len[8*i +: 8] = 8'($urandom);
      fifo_idx[9*i +: 9] = 9'($urandom);
    end
    rw = 3'($urandom);
    fifo_wen = 3'($urandom);
  endtask
  task automatic run_txn(input logic [2:0] r, input bit rnd, input bit wrong_rel, output int s, output logic [2:0] g);
    logic [63:0] ea;
    logic [7:0] el;
    logic ew;
    logic [2:0] wr;
    int dly, wc;
    dly = $urandom_range(0, 2);
    wc = $urandom_range(0, 8);
    req = r;
    m_ready = 0;
    repeat (dly) begin
      tick;
      chk("idle_gnt", gnt, 0);
      chk("idle_mreq", m_req, 0);
    end
    m_ready = 1;
    s = pick(r);
    ea = addr[64*s +: 64];
    el = len[8*s +: 8];
    ew = rw[s];
    tick;
    g = gnt;
    m_ready = 0;
    chk("grant", gnt, 64'(1) << s);
    chk("mreq_on", m_req, 1);
    chk("maddr", m_addr, ea);
    chk("mlen", m_len, el);
    chk("mrw", m_rw, ew);
    if (rnd) begin
      rand_fields;
      if ($urandom_range(0, 1) == 1) req[s] = 1'b0;
    end
    tick;
    chk("mreq_off", m_req, 0);
    chk("grant_hold", gnt, 64'(1) << s);
    chk("maddr_hold", m_addr, ea);
    chk("mlen_hold", m_len, el);
    chk("fifo_idx", m_fifo_idx, fifo_idx[9*s +: 9]);
    chk("fifo_wdata", m_fifo_wdata, fifo_wdata[64*s +: 64]);
    chk("fifo_wen", m_fifo_wen, fifo_wen[s]);
    repeat (wc) tick;
    chk("done_early", done, 0);
    m_done = 1;
    if (wrong_rel) begin
      wr = 3'($urandom_range(1, 7)) & ~(3'b1 << s);
      if (wr == 0) wr = 3'b1 << ((s + 1) % 3);
      release_req = wr;
      #1;
      chk("done_sel", done, 64'(1) << s);
      chk("wrong_rel", m_release, 0);
      tick;
      chk("stay_wait", gnt, 64'(1) << s);
    end
    release_req = (3'b1 << s) | 3'($urandom);
    #1;
    chk("done_sel", done, 64'(1) << s);
    chk("mrelease", m_release, 1);
    tick;
    model_last = s;
    m_done = 0;
    release_req = 0;
    chk("idle_after", gnt, 0);
    chk("idle_addr", m_addr, 0);
    chk("idle_fwen", m_fifo_wen, 0);
    chk("no_timeout", timeout_err, 0);
  endtask
  initial begin
    int s;
    logic [2:0] g, r;
    int ord[4] = '{0, 1, 2, 0};
    repeat (2) tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_mreq", m_req, 0);
    chk("rst_done", done, 0);
    chk("rst_rel", m_release, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_port", timeout_port, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      rand_fields;
      run_txn(3'b111, 0, 0, s, g);
      chk("rotation", g, 64'(1) << ord[i]);
    end
    rand_fields;
    addr[63:0] = 64'h8000_0040;
    len[7:0] = 8'd7;
    run_txn(3'b001, 1, 0, s, g);
    chk("directed_p0", g, 3'b001);
    rand_fields;
    run_txn(3'b010, 1, 1, s, g);
    chk("directed_p1", g, 3'b010);
    rand_fields;
    rw[2] = 1'b1;
    fifo_idx[26:18] = 9'd64;
    fifo_wen = 3'b101;
    fifo_idx[8:0] = 9'd3;
    run_txn(3'b100, 0, 0, s, g);
    chk("directed_p2", g, 3'b100);
    for (int i = 0; i < 40; i++) begin
      rand_fields;
      r = 3'($urandom_range(1, 7));
      run_txn(r, 1, $urandom_range(0, 1) == 1, s, g);
    end
    rand_fields;
    r = 3'($urandom_range(1, 7));
    req = r;
    m_ready = 1;
    s = pick(r);
    tick;
    m_ready = 0;
    chk("to_grant", gnt, 64'(1) << s);
    repeat (16) tick;
    chk("to_early", timeout_err, 0);
    tick;
    chk("to_err", timeout_err, 1);
    chk("to_port", timeout_port, 2'(s));
    chk("to_stay", gnt, 64'(1) << s);
    m_done = 1;
    release_req = 3'b1 << s;
    tick;
    model_last = s;
    m_done = 0;
    release_req = 0;
    chk("to_idle", gnt, 0);
    chk("to_sticky", timeout_err, 1);
    rand_fields;
    req = 3'b001;
    m_ready = 1;
    s = pick(3'b001);
    tick;
    m_ready = 0;
    tick;
    tick;
    chk("mid_busy", gnt, 64'(1) << s);
    rst = 1;
    tick;
    rst = 0;
    model_last = 2;
    chk("mid_gnt", gnt, 0);
    chk("mid_mreq", m_req, 0);
    chk("mid_rel", m_release, 0);
    chk("mid_err", timeout_err, 0);
    chk("mid_port", timeout_port, 0);
    rand_fields;
    run_txn(3'b110, 1, 0, s, g);
    chk("post_rst_p1", g, 3'b010);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requester ports (fixed at 3 in this revision).
REQ-002 Parameter TIMEOUT, default 4096, cycles allowed in WAIT_DONE before the timeout flag is raised.
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  3  per-port request; port i asserts req[i] and holds it until done[i].
REQ-006 rw  in  3  per-port direction; 0 = read, 1 = write.
REQ-007 addr  in  192  per-port address, 64b slice per port (port i = bits 64i+63:64i).
REQ-008 len  in  24  per-port AXI burst length, 8b slice per port.
REQ-009 fifo_idx  in  27  per-port 9b line-buffer bit index.
REQ-010 fifo_wdata  in  192  per-port 64b line-buffer write data.
REQ-011 fifo_wen  in  3  per-port line-buffer write enable.
REQ-012 release  in  3  per-port "line consumed" strobe.
REQ-013 gnt  out  3  one-hot grant; at most one bit set.
REQ-014 done  out  3  per-port completion.
REQ-015 m_req, m_rw  out  1, 1  downstream request pulse and direction.
REQ-016 m_addr, m_len  out  64, 8  downstream address and burst length.
REQ-017 m_fifo_idx, m_fifo_wdata, m_fifo_wen  out  9, 64, 1  muxed line-buffer signals.
REQ-018 m_release  out  1  downstream line-buffer done strobe.
REQ-019 m_ready, m_done  in  1, 1  downstream idle, downstream transfer complete.
REQ-020 timeout_err  out  1  sticky watchdog flag; timeout_port  out  2  port that timed out.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_DONE.
REQ-022 IDLE: when m_ready=1 and req!=0, the arbiter SHALL select the first requesting port after last_gnt in the order 0->1->2->0, latch sel, rw, addr and len, and go to ISSUE.
REQ-023 If m_ready=0, the arbiter SHALL stay in IDLE and leave gnt at 0.
REQ-024 ISSUE: m_req SHALL be 1 for exactly one cycle with the latched m_rw/m_addr/m_len, then the FSM SHALL go to WAIT_DONE.
REQ-025 gnt[sel] SHALL be 1 in ISSUE and WAIT_DONE and 0 in IDLE; latency from req sampled in IDLE to gnt/m_req is 1 cycle.
REQ-026 m_addr, m_rw and m_len SHALL hold the latched values until the FSM returns to IDLE and SHALL read 0 in IDLE.
REQ-027 While not IDLE, m_fifo_idx/m_fifo_wdata/m_fifo_wen SHALL combinationally follow port sel; in IDLE they SHALL be 0.
REQ-028 done[sel] SHALL equal m_done while in WAIT_DONE; all other done bits SHALL be 0.
REQ-029 m_release SHALL equal release[sel] & m_done & (state==WAIT_DONE).
REQ-030 A release from a non-selected port, or a release before m_done, SHALL be ignored.
REQ-031 On the m_release cycle: last_gnt<=sel and next state is IDLE; a new grant is possible at the earliest 1 cycle later.
REQ-032 Latched request fields SHALL be unaffected by requester inputs changing after the grant, including req[sel] dropping.
REQ-033 Watchdog: a 13b counter clears on entering WAIT_DONE and increments each WAIT_DONE cycle with m_done=0.
REQ-034 When the watchdog reaches TIMEOUT, timeout_err SHALL set (sticky until rst) and timeout_port<=sel; the FSM SHALL remain in WAIT_DONE with no abort.
REQ-035 All three ports requesting continuously SHALL be granted in rotation, each within 3 transactions.

Reset
REQ-036 rst SHALL force IDLE and last_gnt=2 (port 0 wins first), and zero gnt, done, m_req, m_release, the watchdog counter, timeout_err and timeout_port.
REQ-037 rst asserted mid-transaction SHALL drop gnt and m_req in the following cycle with no m_release emitted.

Verification
REQ-038 req=3'b001, m_ready=1, addr0=0x8000_0040, len0=7 -> next cycle gnt=001, m_req=1 for one cycle, m_addr=0x8000_0040, m_len=7.
REQ-039 req=3'b111 held, each transaction completed with m_done+release -> grant order 0,1,2,0.
REQ-040 Granted port 1: m_done=1 with release=3'b001 -> m_release=0, stays WAIT_DONE; release=3'b010 -> m_release=1, IDLE next cycle.
REQ-041 Granted write on port 2, fifo_idx2=64, fifo_wen2=1 -> m_fifo_idx=64, m_fifo_wen=1; port 0 fifo activity ignored.
REQ-042 TIMEOUT=16, m_done held 0 -> timeout_err=1 and timeout_port=sel after 16 WAIT_DONE cycles; cleared only by rst.
REQ-043 rst pulsed in WAIT_DONE -> all outputs 0 next cycle; then req=3'b110 -> port 1 granted.
